// File: rtl/datapath_display_pkg.sv
// datapath_display_pkg: shared source-select encodings, hex glyphs and blanking constants
//   SEL_*    : source select codes (PC, WriteData, Hi, Lo)
//   GLYPH_*  : active-low 7-segment glyphs, bit order g,f,e,d,c,b,a
//   AN_OFF / SEG_OFF : all anodes off / all segments off
package datapath_display_pkg;
    typedef enum logic [1:0] {SEL_PC, SEL_WD, SEL_HI, SEL_LO} sel_e;
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;
    localparam logic [15:0][6:0] GLYPHS = {GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C,
                                           GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
                                           GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4,
                                           GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0};
    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;
endpackage

// File: rtl/datapath_display_if.sv
// datapath_display_if: datapath sources, select/freeze controls and display drive
//   PC, WriteData, Hi, Lo : 32-bit sources
//   sel, freeze           : source select and snapshot hold
//   an, seg, dp           : active-low anodes, segments, decimal point
//   master = source/controller side, slave = display block
interface datapath_display_if;
    logic [31:0] PC;
    logic [31:0] WriteData;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [1:0]  sel;
    logic        freeze;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    modport master (output PC, WriteData, Hi, Lo, sel, freeze, input an, seg, dp);
    modport slave  (input PC, WriteData, Hi, Lo, sel, freeze, output an, seg, dp);
endinterface

// File: rtl/hex7seg.sv
// hex7seg: nibble to active-low 7-segment glyph
//   i_nib : hex digit value
//   o_seg : segments g,f,e,d,c,b,a, active-low
module hex7seg
    import datapath_display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = GLYPHS[i_nib];
endmodule

// File: rtl/datapath_display.sv
// datapath_display: 8-digit multiplexed hex display of a selectable datapath register
//   clkin : clock
//   rst   : asynchronous active-low reset
//   bus   : sources, sel/freeze in; an/seg/dp out (registered, active-low)
module datapath_display
    import datapath_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 2
) (
    input  logic               clkin,
    input  logic               rst,
    datapath_display_if.slave  bus
);
    localparam logic [0:0]  S_SHOW     = 1'b0;
    localparam logic [0:0]  S_BLANK    = 1'b1;
    localparam logic [15:0] SHOW_LAST  = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);
    logic [0:0]  r_state;
    logic [2:0]  r_digit;
    logic [15:0] r_cnt;
    logic [31:0] r_snap;
    logic [1:0]  r_selq;
    logic        r_first;
    logic [7:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic        w_show_end;
    logic        w_blank_end;
    logic        w_load;
    logic [31:0] w_src;
    logic [3:0]  w_nib;
    logic [6:0]  w_glyph;
    assign w_show_end  = r_state == S_SHOW  && r_cnt == SHOW_LAST;
    assign w_blank_end = r_state == S_BLANK && r_cnt == BLANK_LAST;
    // sources are only sampled at the frame boundary (or the first edge out of reset),
    // so a frame is never a mix of two source values
    assign w_load = ((w_blank_end && r_digit == 3'd7) || r_first) && !bus.freeze;
    assign w_src  = bus.sel == SEL_PC ? bus.PC :
                    bus.sel == SEL_WD ? bus.WriteData :
                    bus.sel == SEL_HI ? bus.Hi : bus.Lo;
    assign w_nib  = r_snap[{r_digit, 2'b00} +: 4];
    hex7seg u_hex (.i_nib(w_nib), .o_seg(w_glyph));
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            r_state <= S_SHOW;
            r_digit <= 3'd0;
            r_cnt   <= 16'd0;
            r_snap  <= 32'd0;
            r_selq  <= 2'd0;
            r_first <= 1'b1;
            r_an    <= AN_OFF;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (w_load) begin
                r_snap <= w_src;
                r_selq <= bus.sel;
            end
            if (w_show_end) begin
                r_state <= S_BLANK;
                r_cnt   <= 16'd0;
            end else if (w_blank_end) begin
                r_state <= S_SHOW;
                r_cnt   <= 16'd0;
                r_digit <= r_digit + 3'd1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            r_an  <= r_state == S_SHOW ? ~(8'd1 << r_digit) : AN_OFF;
            r_seg <= r_state == S_SHOW ? w_glyph : SEG_OFF;
            r_dp  <= r_state == S_SHOW ? r_digit != {1'b0, r_selq} : 1'b1;
        end
    end
    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
endmodule
